// File: rtl/pit_pkg.sv
// PIT shared definitions: counter width, counter type and counter reset value.
// Shared with the prescaler and bus-register blocks of the PIT.
package pit_pkg;

  localparam int PIT_COUNT_SIZE = 16;

  typedef logic [PIT_COUNT_SIZE-1:0] pit_cnt_t;

  // Counter restarts at 1 so that cnt_n runs 1..mod_value.
  localparam pit_cnt_t PIT_CNT_RST = pit_cnt_t'(1);

endpackage

// File: rtl/pit_mod_counter_if.sv
// Interface bundling the modulo counter's control inputs and status outputs.
// master: prescaler / register side; slave: the modulo counter.
interface pit_mod_counter_if #(
  parameter int COUNT_SIZE = pit_pkg::PIT_COUNT_SIZE
);

  logic                  counter_sync;
  logic                  prescale_in;
  logic [COUNT_SIZE-1:0] mod_value;
  logic                  cnt_flag_clr;
  logic                  irq_en;
  logic [COUNT_SIZE-1:0] cnt_n;
  logic                  cnt_flag_o;
  logic                  pit_irq_o;
  logic                  pit_o;

  modport master (
    output counter_sync, prescale_in, mod_value, cnt_flag_clr, irq_en,
    input  cnt_n, cnt_flag_o, pit_irq_o, pit_o
  );

  modport slave (
    input  counter_sync, prescale_in, mod_value, cnt_flag_clr, irq_en,
    output cnt_n, cnt_flag_o, pit_irq_o, pit_o
  );

endinterface

// File: rtl/pit_event_flag.sv
// Sticky event flag: set has priority over clear; irq_o is the flag gated
// by an enable, combinational so it tracks both flag and enable immediately.
module pit_event_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic en,
  output logic flag_o,
  output logic irq_o
);

  logic flag_d, flag_q;

  // Next flag: a coincident set beats a clear so no event is lost.
  always_comb begin
    flag_d = flag_q;
    if (set)      flag_d = 1'b1;
    else if (clr) flag_d = 1'b0;
  end

  // Flag register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end

  assign flag_o = flag_q;
  assign irq_o  = flag_q & en;

endmodule

// File: rtl/pit_mod_counter.sv
// PIT modulo counter: counts prescale ticks 1..mod_eff, emits a one-cycle
// pit_o pulse on the terminal tick and sets a sticky rollover flag.
// Optional macro PIT_MOD_SHADOW_EN: compare against a shadow copy of
// mod_value that only updates at period boundaries (reset, disabled, rollover).
module pit_mod_counter
  import pit_pkg::*;
#(
  parameter int COUNT_SIZE = PIT_COUNT_SIZE
) (
  input  logic              bus_clk,
  input  logic              sync_reset,
  pit_mod_counter_if.slave  pit
);

  localparam logic [COUNT_SIZE-1:0] CNT_ONE = COUNT_SIZE'(PIT_CNT_RST);

  logic [COUNT_SIZE-1:0] cnt_d, cnt_q;
  logic                  pit_d, pit_q;
  logic [COUNT_SIZE-1:0] mod_eff;
  logic                  term;
  logic                  rollover;

`ifdef PIT_MOD_SHADOW_EN
  logic [COUNT_SIZE-1:0] mod_sh_d, mod_sh_q;

  // Shadow reloads whenever a new period starts, so mid-period writes
  // only take effect from the next period.
  always_comb begin
    mod_sh_d = mod_sh_q;
    if (!pit.counter_sync || rollover) mod_sh_d = pit.mod_value;
  end

  // Shadow register, loaded from the live value during reset.
  always_ff @(posedge bus_clk) begin
    if (sync_reset) mod_sh_q <= pit.mod_value;
    else            mod_sh_q <= mod_sh_d;
  end

  assign mod_eff = mod_sh_q;
`else
  assign mod_eff = pit.mod_value;
`endif

  // >= rather than == so that lowering mod below the current count rolls
  // over on the next tick instead of wrapping through 2^N.
  assign term     = (mod_eff <= CNT_ONE) || (cnt_q >= mod_eff);
  assign rollover = pit.counter_sync & pit.prescale_in & term;

  // Next count and pulse: disabled forces restart at 1, ticks advance or roll.
  always_comb begin
    cnt_d = cnt_q;
    pit_d = 1'b0;
    if (!pit.counter_sync) begin
      cnt_d = CNT_ONE;
    end else if (pit.prescale_in) begin
      if (term) begin
        cnt_d = CNT_ONE;
        pit_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Counter and registered pulse with synchronous reset.
  always_ff @(posedge bus_clk) begin
    if (sync_reset) begin
      cnt_q <= CNT_ONE;
      pit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pit_q <= pit_d;
    end
  end

  pit_event_flag u_flag (
    .clk    (bus_clk),
    .rst    (sync_reset),
    .set    (rollover),
    .clr    (pit.cnt_flag_clr),
    .en     (pit.irq_en),
    .flag_o (pit.cnt_flag_o),
    .irq_o  (pit.pit_irq_o)
  );

  assign pit.cnt_n = cnt_q;
  assign pit.pit_o = pit_q;

endmodule
